pipe_hazard_ctrl: RTL and testbench

//  Pipeline sequencer for the RV32I core. Generates stall, flush and bubble

---
 rtl/pipe_hazard_ctrl.sv | 110 +++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush/bubble sequencer for load-use, memory wait and taken-branch hazards
module pipe_hazard_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int LD_STALL     = 1,
    parameter int CNT_W        = 8,
    parameter int MEM_TIMEOUT  = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clkEn,
    input  logic [4:0] dec_rs1,
    input  logic [4:0] dec_rs2,
    input  logic       dec_use_rs1,
    input  logic       dec_use_rs2,
    input  logic       ex_memLd,
    input  logic [4:0] ex_reg_d,
    input  logic       ex_br_taken,
    input  logic       mem_req,
    input  logic       mem_ack,
    output logic       stall,
    output logic       jmp,
    output logic       pc_en,
    output logic       bubble_ex,
    output logic       mem_timeout,
    output logic [1:0] state_dbg
);
    typedef enum logic [1:0] {RUN = 2'd0, LDUSE = 2'd1, FLUSH = 2'd2, MEMWAIT = 2'd3} state_t;
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] FL_INIT = CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] LD_INIT = CNT_W'(LD_STALL - 1);
    localparam logic [CNT_W-1:0] TO_CNT  = CNT_W'(MEM_TIMEOUT);
    state_t state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic to_nx, hazard, memwait, st, jp, pe, bb;
    assign hazard = ex_memLd && ex_reg_d != 5'd0 &&
                    ((dec_use_rs1 && dec_rs1 == ex_reg_d) || (dec_use_rs2 && dec_rs2 == ex_reg_d));
    assign memwait = mem_req && !mem_ack;
    assign state_dbg = state;
    always_comb begin
        state_nx = state;
        cnt_nx = cnt;
        to_nx = mem_timeout;
        st = 1'b0;
        jp = 1'b0;
        pe = 1'b0;
        bb = 1'b0;
        // memory wait freezes everything and wins over any branch or load-use work in flight
        if (state != MEMWAIT && memwait) begin
            st = 1'b1;
            state_nx = MEMWAIT;
            cnt_nx = ONE;
        end else begin
            case (state)
                RUN: begin
                    if (ex_br_taken) begin
                        jp = 1'b1;
                        pe = 1'b1;
                        state_nx = FLUSH_CYCLES > 1 ? FLUSH : RUN;
                        cnt_nx = FL_INIT;
                    end else if (hazard) begin
                        st = 1'b1;
                        bb = 1'b1;
                        state_nx = LD_STALL > 1 ? LDUSE : RUN;
                        cnt_nx = LD_INIT;
                    end else begin
                        pe = 1'b1;
                    end
                end
                LDUSE: begin
                    st = 1'b1;
                    bb = 1'b1;
                    cnt_nx = cnt - ONE;
                    state_nx = cnt == ONE ? RUN : LDUSE;
                end
                FLUSH: begin
                    jp = 1'b1;
                    pe = 1'b1;
                    cnt_nx = cnt - ONE;
                    state_nx = cnt == ONE ? RUN : FLUSH;
                end
                default: begin
                    st = 1'b1;
                    if (mem_ack) begin
                        state_nx = RUN;
                    end else if (cnt == TO_CNT) begin
                        to_nx = 1'b1;
                        state_nx = RUN;
                    end else begin
                        cnt_nx = &cnt ? cnt : cnt + ONE;
                    end
                end
            endcase
        end
        stall = st && clkEn && !rst;
        jmp = jp && clkEn && !rst;
        pc_en = pe && clkEn && !rst;
        bubble_ex = bb && clkEn && !rst;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            cnt <= '0;
            mem_timeout <= 1'b0;
        end else if (clkEn) begin
            state <= state_nx;
            cnt <= cnt_nx;
            mem_timeout <= to_nx;
        end
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed checks on two sequencer configurations sharing one stimulus
module tb_pipe_hazard_ctrl;
    logic clk = 1'b0, rst = 1'b1, clk_en = 1'b1;
    logic [4:0] dec_rs1, dec_rs2, ex_reg_d;
    logic dec_use_rs1, dec_use_rs2, ex_mem_ld, ex_br_taken, mem_req, mem_ack;
    logic sa, ja, pa, ba, ta, sb, jb, pb, bb, tb;
    logic [1:0] da, db;
    logic [6:0] oa, ob;
    int n_tests = 0, n_fail = 0;
    always #5 clk = ~clk;
    pipe_hazard_ctrl u_a (
        .clk(clk), .rst(rst), .clkEn(clk_en), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
        .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2), .ex_memLd(ex_mem_ld),
        .ex_reg_d(ex_reg_d), .ex_br_taken(ex_br_taken), .mem_req(mem_req), .mem_ack(mem_ack),
        .stall(sa), .jmp(ja), .pc_en(pa), .bubble_ex(ba), .mem_timeout(ta), .state_dbg(da)
    );
    pipe_hazard_ctrl #(.FLUSH_CYCLES(2), .LD_STALL(4), .CNT_W(8), .MEM_TIMEOUT(8)) u_b (
        .clk(clk), .rst(rst), .clkEn(clk_en), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
        .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2), .ex_memLd(ex_mem_ld),
        .ex_reg_d(ex_reg_d), .ex_br_taken(ex_br_taken), .mem_req(mem_req), .mem_ack(mem_ack),
        .stall(sb), .jmp(jb), .pc_en(pb), .bubble_ex(bb), .mem_timeout(tb), .state_dbg(db)
    );
    assign oa = {da, sa, ja, pa, ba, ta};
    assign ob = {db, sb, jb, pb, bb, tb};
    function automatic logic [6:0] pk(input logic [1:0] s, input logic st, jp, pe, bu, to);
        return {s, st, jp, pe, bu, to};
    endfunction
    task automatic check(input string tag, input logic [6:0] got, input logic [6:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got {st,stall,jmp,pc_en,bub,to}=%b_%b expected %b_%b",
                     tag, got[6:5], got[4:0], exp[6:5], exp[4:0]);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic idle();
        {dec_rs1, dec_rs2, ex_reg_d} = '0;
        {dec_use_rs1, dec_use_rs2, ex_mem_ld, ex_br_taken, mem_req, mem_ack} = '0;
    endtask
    task automatic haz(input logic [4:0] rd);
        ex_mem_ld = 1'b1;
        ex_reg_d = rd;
        dec_rs1 = rd;
        dec_use_rs1 = 1'b1;
    endtask
    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask
    initial begin
        idle();
        tick();
        #1 check("rst_outs", oa, pk(0, 0, 0, 0, 0, 0));
        rst = 1'b0;
        #1 check("run_idle", oa, pk(0, 0, 0, 1, 0, 0));
        haz(5'd5);
        #1 check("ld_use", oa, pk(0, 1, 0, 0, 1, 0));
        tick();
        idle();
        #1 check("ld_use_done", oa, pk(0, 0, 0, 1, 0, 0));
        haz(5'd0);
        #1 check("x0_no_haz", oa, pk(0, 0, 0, 1, 0, 0));
        haz(5'd7);
        dec_use_rs1 = 1'b0;
        #1 check("rs1_unused", oa, pk(0, 0, 0, 1, 0, 0));
        dec_rs1 = 5'd3;
        dec_rs2 = 5'd7;
        dec_use_rs2 = 1'b1;
        #1 check("rs2_haz", oa, pk(0, 1, 0, 0, 1, 0));
        ex_mem_ld = 1'b0;
        #1 check("not_load", oa, pk(0, 0, 0, 1, 0, 0));
        do_reset();
        ex_br_taken = 1'b1;
        #1 check("br_run", oa, pk(0, 0, 1, 1, 0, 0));
        tick();
        ex_br_taken = 1'b1;
        haz(5'd9);
        #1 check("flush_ign", oa, pk(2, 0, 1, 1, 0, 0));
        tick();
        idle();
        #1 check("flush_end", oa, pk(0, 0, 0, 1, 0, 0));
        mem_req = 1'b1;
        #1 check("mw_enter", oa, pk(0, 1, 0, 0, 0, 0));
        for (int i = 1; i <= 3; i++) begin
            tick();
            #1 check($sformatf("mw_hold%0d", i), oa, pk(3, 1, 0, 0, 0, 0));
        end
        tick();
        mem_ack = 1'b1;
        #1 check("mw_ack", oa, pk(3, 1, 0, 0, 0, 0));
        tick();
        idle();
        #1 check("mw_exit", oa, pk(0, 0, 0, 1, 0, 0));
        do_reset();
        mem_req = 1'b1;
        #1 check("to_enter", ob, pk(0, 1, 0, 0, 0, 0));
        for (int i = 1; i <= 8; i++) begin
            tick();
            #1 check($sformatf("to_wait%0d", i), ob, pk(3, 1, 0, 0, 0, 0));
        end
        tick();
        #1 check("to_set", ob, pk(0, 1, 0, 0, 0, 1));
        mem_req = 1'b0;
        tick();
        tick();
        #1 check("to_sticky", ob, pk(0, 0, 0, 1, 0, 1));
        do_reset();
        #1 check("to_clear", ob, pk(0, 0, 0, 1, 0, 0));
        haz(5'd4);
        ex_br_taken = 1'b1;
        #1 check("br_over_haz", oa, pk(0, 0, 1, 1, 0, 0));
        tick();
        mem_req = 1'b1;
        #1 check("flush_mw", oa, pk(2, 1, 0, 0, 0, 0));
        tick();
        #1 check("mw_br_ign", oa, pk(3, 1, 0, 0, 0, 0));
        mem_ack = 1'b1;
        tick();
        idle();
        #1 check("no_flush_resume", oa, pk(0, 0, 0, 1, 0, 0));
        do_reset();
        haz(5'd6);
        #1 check("ld4_run", ob, pk(0, 1, 0, 0, 1, 0));
        tick();
        idle();
        for (int i = 1; i <= 3; i++) begin
            #1 check($sformatf("ld4_bub%0d", i), ob, pk(1, 1, 0, 0, 1, 0));
            tick();
        end
        #1 check("ld4_done", ob, pk(0, 0, 0, 1, 0, 0));
        haz(5'd6);
        tick();
        idle();
        tick();
        rst = 1'b1;
        #1 check("rst_in_lduse", ob, pk(1, 0, 0, 0, 0, 0));
        tick();
        rst = 1'b0;
        #1 check("rst_to_run", ob, pk(0, 0, 0, 1, 0, 0));
        ex_br_taken = 1'b1;
        tick();
        ex_br_taken = 1'b0;
        clk_en = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            #1 check($sformatf("clken_hold%0d", i), ob, pk(2, 0, 0, 0, 0, 0));
            tick();
        end
        clk_en = 1'b1;
        #1 check("clken_resume", ob, pk(2, 0, 1, 1, 0, 0));
        tick();
        #1 check("clken_done", ob, pk(0, 0, 0, 1, 0, 0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
